// File: rtl/comm_pkg.sv
// Shared types and constants for the copter-side command link.
package comm_pkg;

    // Bytes per command frame: cmd, data_hi, data_lo
    localparam int FRAME_BYTES = 3;

    // Receive FSM: which byte of the frame is expected next
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_HI = 2'd1,
        WAIT_LO = 2'd2
    } rx_state_t;

    // Transmit FSM: waiting for a response request, or a byte is on the wire
    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_BUSY = 1'b1
    } tx_state_t;

    // Command opcodes understood by the command-config logic
    localparam logic [7:0] CMD_SET_PTCH  = 8'h02;
    localparam logic [7:0] CMD_SET_ROLL  = 8'h03;
    localparam logic [7:0] CMD_SET_YAW   = 8'h04;
    localparam logic [7:0] CMD_SET_THRST = 8'h05;
    localparam logic [7:0] CMD_CAL       = 8'h06;
    localparam logic [7:0] CMD_EMER_LAND = 8'h07;
    localparam logic [7:0] CMD_MTRS_OFF  = 8'h08;

    // Response bytes returned to the ground-side master
    localparam logic [7:0] RESP_ACK      = 8'hA5;
    localparam logic [7:0] RESP_CAL_DONE = 8'h5A;

endpackage

// File: rtl/comm_slave.sv
// Copter-side command link endpoint: assembles 3-byte frames from the UART
// receiver into cmd/data, and forwards one response byte to the UART
// transmitter. Receive and transmit paths are fully independent.
module comm_slave
    import comm_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1000000,
    parameter int TMR_W       = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    // UART receiver side
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rx_rdy,
    // command-config side
    output logic [7:0]  cmd,
    output logic [15:0] data,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    input  logic [7:0]  resp,
    output logic        resp_sent,
    // UART transmitter side
    output logic        trmt,
    output logic [7:0]  tx_data,
    input  logic        tx_done
);

    rx_state_t        rx_state;
    tx_state_t        tx_state;
    logic [TMR_W-1:0] tmr;
    logic             accept;
    logic             timeout;

    // rx_rdy is a level held until cleared; masking with our own clear pulse
    // guarantees each byte is consumed exactly once.
    assign accept  = rx_rdy & ~clr_rx_rdy;

    // An arriving byte beats the timeout in the same cycle.
    assign timeout = (rx_state != IDLE) && !accept &&
                     (tmr == TMR_W'(TIMEOUT_CYC - 1));

    // Acknowledge each accepted byte with a single-cycle pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) clr_rx_rdy <= 1'b0;
        else        clr_rx_rdy <= accept;
    end

    // Receive FSM: track the position within the current frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= IDLE;
        end else begin
            case (rx_state)
                IDLE:    if (accept) rx_state <= WAIT_HI;
                WAIT_HI: if (accept) rx_state <= WAIT_LO;
                         else if (timeout) rx_state <= IDLE;
                WAIT_LO: if (accept || timeout) rx_state <= IDLE;
                default: rx_state <= IDLE;
            endcase
        end
    end

    // Inter-byte timer: idle outside a partial frame, restarts on each byte,
    // saturates rather than wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tmr <= '0;
        else if (rx_state == IDLE || accept || timeout)
            tmr <= '0;
        else if (tmr != '1)
            tmr <= tmr + TMR_W'(1);
    end

    // Frame registers: each byte lands in its slot as soon as it is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd  <= 8'h00;
            data <= 16'h0000;
        end else if (accept) begin
            case (rx_state)
                IDLE:    cmd        <= rx_data;
                WAIT_HI: data[15:8] <= rx_data;
                WAIT_LO: data[7:0]  <= rx_data;
                default: ;
            endcase
        end
    end

    // Frame-ready flag: completion beats a simultaneous consumer clear; a new
    // frame's first byte withdraws the stale frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cmd_rdy <= 1'b0;
        else if (accept && rx_state == WAIT_LO)
            cmd_rdy <= 1'b1;
        else if ((accept && rx_state == IDLE) || clr_cmd_rdy)
            cmd_rdy <= 1'b0;
    end

    // Transmit FSM: launch one response byte, then wait for the UART to finish;
    // requests arriving while busy are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state  <= TX_IDLE;
            tx_data   <= 8'h00;
            trmt      <= 1'b0;
            resp_sent <= 1'b0;
        end else begin
            trmt      <= 1'b0;
            resp_sent <= 1'b0;
            case (tx_state)
                TX_IDLE: if (send_resp) begin
                    tx_data  <= resp;
                    trmt     <= 1'b1;
                    tx_state <= TX_BUSY;
                end
                TX_BUSY: if (tx_done) begin
                    resp_sent <= 1'b1;
                    tx_state  <= TX_IDLE;
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_comm_slave.sv
// Bench for comm_slave: directed frames/responses, a transaction-level model
// compared every cycle, and literal expectations at key points.
module tb_comm_slave;

    localparam int T = 300;
    localparam int W = 9;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_rdy = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        clr_cmd_rdy = 1'b0;
    logic        send_resp = 1'b0;
    logic [7:0]  resp = 8'h00;
    logic        tx_done = 1'b0;
    logic        clr_rx_rdy, cmd_rdy, resp_sent, trmt;
    logic [7:0]  cmd, tx_data;
    logic [15:0] data;

    comm_slave #(.TIMEOUT_CYC(T), .TMR_W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_rdy(rx_rdy), .rx_data(rx_data), .clr_rx_rdy(clr_rx_rdy),
        .cmd(cmd), .data(data), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
        .send_resp(send_resp), .resp(resp), .resp_sent(resp_sent),
        .trmt(trmt), .tx_data(tx_data), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int n_clr = 0;
    int n_sent = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // ---------------- model ----------------
    logic [7:0]  m_q[$];
    int          cyc = 0;
    int          m_last = 0;
    logic        e_clr = 0, e_rdy = 0, e_trmt = 0, e_sent = 0, m_busy = 0;
    logic [7:0]  e_cmd = 0, e_tx = 0;
    logic [15:0] e_data = 0;
    logic        s_rst, s_rx, s_ccr, s_send, s_done, acc;
    logic [7:0]  s_rxd, s_resp;

    initial begin
        forever begin
            @(posedge clk);
            s_rst = rst_n; s_rx = rx_rdy; s_rxd = rx_data; s_ccr = clr_cmd_rdy;
            s_send = send_resp; s_resp = resp; s_done = tx_done;
            cyc++;
            if (!s_rst) begin
                m_q.delete();
                e_clr = 0; e_rdy = 0; e_trmt = 0; e_sent = 0; m_busy = 0;
                e_cmd = 0; e_tx = 0; e_data = 0;
            end else begin
                acc = s_rx && !e_clr;
                e_clr = acc;
                if (s_ccr) e_rdy = 0;
                // partial frame abandoned after T clocks without a byte
                if (m_q.size() > 0 && !acc && (cyc - m_last) == T) m_q.delete();
                if (acc) begin
                    m_last = cyc;
                    m_q.push_back(s_rxd);
                    case (m_q.size())
                        1: begin e_cmd = s_rxd; e_rdy = 0; end
                        2: e_data[15:8] = s_rxd;
                        default: begin e_data[7:0] = s_rxd; e_rdy = 1; m_q.delete(); end
                    endcase
                end
                e_trmt = 0; e_sent = 0;
                if (!m_busy && s_send) begin
                    e_tx = s_resp; e_trmt = 1; m_busy = 1;
                end else if (m_busy && s_done) begin
                    e_sent = 1; m_busy = 0;
                end
            end
            #1;
            chk("clr_rx_rdy", clr_rx_rdy, e_clr);
            chk("cmd_rdy", cmd_rdy, e_rdy);
            chk("cmd", cmd, e_cmd);
            chk("data", data, e_data);
            chk("trmt", trmt, e_trmt);
            chk("tx_data", tx_data, e_tx);
            chk("resp_sent", resp_sent, e_sent);
            if (clr_rx_rdy) n_clr++;
            if (resp_sent) n_sent++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Behaves like the UART receiver: hold rx_rdy until the clear pulse.
    // Called and returns on a negedge.
    task automatic send_byte(input logic [7:0] b, input logic ccr);
        bit got = 0;
        rx_rdy = 1'b1; rx_data = b; clr_cmd_rdy = ccr;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            clr_cmd_rdy = 1'b0;
            if (clr_rx_rdy) got = 1;
        end
        rx_rdy = 1'b0;
        if (!got) chk("clr_rx_rdy handshake", 0, 1);
    endtask

    task automatic pulse_send(input logic [7:0] r);
        resp = r; send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
    endtask

    task automatic pulse_done();
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " cmd"}, cmd, 8'h00);
        chk({tag, " data"}, data, 16'h0000);
        chk({tag, " cmd_rdy"}, cmd_rdy, 1'b0);
        chk({tag, " trmt"}, trmt, 1'b0);
        chk({tag, " tx_data"}, tx_data, 8'h00);
        chk({tag, " clr_rx_rdy"}, clr_rx_rdy, 1'b0);
        chk({tag, " resp_sent"}, resp_sent, 1'b0);
    endtask

    int c0, s0;

    initial begin
        // reset state
        idle(2);
        chk_zero("reset");
        rst_n = 1'b1;
        idle(3);

        // frame assembly, bytes 200 clks apart
        c0 = n_clr;
        send_byte(8'h05, 0); idle(200);
        send_byte(8'h12, 0); idle(200);
        send_byte(8'h34, 0);
        chk("frame1 cmd_rdy", cmd_rdy, 1'b1);
        chk("frame1 cmd", cmd, 8'h05);
        chk("frame1 data", data, 16'h1234);
        idle(2);
        chk("frame1 clr pulses", n_clr - c0, 3);

        // acknowledge keeps data
        clr_cmd_rdy = 1'b1; @(negedge clk); clr_cmd_rdy = 1'b0;
        chk("ack cmd_rdy", cmd_rdy, 1'b0);
        chk("ack data kept", data, 16'h1234);

        // timeout and resync
        send_byte(8'h02, 0); idle(3);
        send_byte(8'hAA, 0); idle(T + 10);
        chk("timeout cmd_rdy", cmd_rdy, 1'b0);
        send_byte(8'h06, 0); idle(3);
        send_byte(8'h00, 0); idle(3);
        send_byte(8'h01, 0);
        chk("resync cmd_rdy", cmd_rdy, 1'b1);
        chk("resync cmd", cmd, 8'h06);
        chk("resync data", data, 16'h0001);

        // new first byte withdraws the pending frame
        idle(2);
        send_byte(8'h11, 0);
        chk("overwrite cmd_rdy drop", cmd_rdy, 1'b0);
        chk("overwrite cmd", cmd, 8'h11);
        chk("overwrite data kept", data, 16'h0001);
        send_byte(8'h22, 0); idle(1);
        send_byte(8'h33, 0);
        chk("overwrite frame data", data, 16'h2233);

        // byte arriving exactly at the timeout cycle wins
        idle(2);
        send_byte(8'h07, 0); idle(T - 1);
        send_byte(8'h08, 0); idle(2);
        send_byte(8'h09, 0);
        chk("edge cmd_rdy", cmd_rdy, 1'b1);
        chk("edge cmd", cmd, 8'h07);
        chk("edge data", data, 16'h0809);

        // one cycle later the partial frame is gone
        idle(2);
        send_byte(8'h07, 0); idle(T);
        send_byte(8'h08, 0); idle(2);
        send_byte(8'h0A, 0); idle(2);
        send_byte(8'h0B, 0);
        chk("late cmd", cmd, 8'h08);
        chk("late data", data, 16'h0A0B);

        // response path
        idle(2);
        s0 = n_sent;
        pulse_send(8'hA5);
        chk("resp trmt", trmt, 1'b1);
        chk("resp tx_data", tx_data, 8'hA5);
        idle(1);
        pulse_send(8'h33);
        chk("busy no trmt", trmt, 1'b0);
        idle(2);
        chk("busy tx_data kept", tx_data, 8'hA5);
        pulse_done();
        chk("resp_sent", resp_sent, 1'b1);
        idle(2);
        chk("resp_sent pulses", n_sent - s0, 1);

        // full duplex with a clear racing frame completion
        pulse_send(8'h5A);
        send_byte(8'h03, 0); idle(2);
        send_byte(8'h44, 0); idle(2);
        send_byte(8'h55, 1);
        chk("race cmd_rdy", cmd_rdy, 1'b1);
        chk("duplex data", data, 16'h4455);
        pulse_done();
        chk("duplex resp_sent", resp_sent, 1'b1);
        chk("duplex tx_data", tx_data, 8'h5A);

        // reset mid-frame, rx_rdy left high across reset
        idle(2);
        send_byte(8'h0C, 0); idle(2);
        send_byte(8'h0D, 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk_zero("midreset");
        rx_rdy = 1'b1; rx_data = 8'h09;
        idle(2);
        rst_n = 1'b1;
        send_byte(8'h09, 0); idle(2);
        send_byte(8'hFF, 0); idle(2);
        send_byte(8'hFE, 0);
        chk("post-reset cmd_rdy", cmd_rdy, 1'b1);
        chk("post-reset cmd", cmd, 8'h09);
        chk("post-reset data", data, 16'hFFFE);

        idle(5);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
